// File: rtl/irig_b_frame_sched_if.sv
// irig_b_frame_sched_if
// Bundles the PPS/time-of-day inputs and the B-code/monitor outputs of the
// IRIG-B frame scheduler.
//   master : time source / observer side (drives pps, time fields)
//   slave  : scheduler side (drives b_code_out, moni_b_code_out, sym_index,
//            frame_start, slip)
interface irig_b_frame_sched_if;
  logic       pps;
  logic       time_valid;
  logic [6:0] sec_bcd;
  logic [6:0] min_bcd;
  logic [5:0] hour_bcd;
  logic [9:0] day_bcd;

  logic       b_code_out;
  logic [7:0] moni_b_code_out;
  logic [6:0] sym_index;
  logic       frame_start;
  logic       slip;

  modport master (
    output pps, time_valid, sec_bcd, min_bcd, hour_bcd, day_bcd,
    input  b_code_out, moni_b_code_out, sym_index, frame_start, slip
  );

  modport slave (
    input  pps, time_valid, sec_bcd, min_bcd, hour_bcd, day_bcd,
    output b_code_out, moni_b_code_out, sym_index, frame_start, slip
  );
endinterface

// File: rtl/irig_b_frame_sched.sv
// irig_b_frame_sched
// Captures BCD time-of-day on each PPS and emits the 100-symbol IRIG-B frame,
// one P/0/1 symbol per (cnt_10ms_max+1) clocks, as a PWM level plus an 8-bit
// monitor code.
// Ports:
//   pll_c0 : system clock (rising edge)
//   rst    : synchronous active-high reset
//   bus    : irig_b_frame_sched_if.slave (pps, time_valid, BCD time in;
//            b_code_out, moni_b_code_out, sym_index, frame_start, slip out)
// Optional feature: define IRIG_B_SBS_EN to emit straight-binary seconds of
// day at symbols 80-88 / 90-97.
module irig_b_frame_sched #(
  parameter logic [31:0] cnt_10ms_max = 32'd1_249_999,
  parameter logic [31:0] cnt_8ms_max  = 32'd999_999,
  parameter logic [31:0] cnt_5ms_max  = 32'd624_999,
  parameter logic [31:0] cnt_2ms_max  = 32'd249_999
) (
  input logic                  pll_c0,
  input logic                  rst,
  irig_b_frame_sched_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StRun, StWait} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [6:0]  sym_q, sym_d;
  logic [6:0]  sec_q, sec_d, min_q, min_d;
  logic [5:0]  hour_q, hour_d;
  logic [9:0]  day_q, day_d;

  logic        b_code_q, b_code_d;
  logic [7:0]  moni_q, moni_d;
  logic        frame_start_q, frame_start_d;
  logic        slip_q, slip_d;

  logic        start, abort;
  logic [99:0] frame_bits;
  logic        sym_p, sym_one;
  logic [31:0] hi_limit;

  assign start = bus.pps & bus.time_valid;
  assign abort = bus.pps & ~bus.time_valid;

`ifdef IRIG_B_SBS_EN
  logic [16:0] sbs_q, sbs_d;
  logic [16:0] h_bin, m_bin, s_bin;

  // Derived from the shadow register, so it settles one cycle into the frame.
  always_comb begin
    h_bin = 17'(hour_q[5:4]) * 17'd10 + 17'(hour_q[3:0]);
    m_bin = 17'(min_q[6:4])  * 17'd10 + 17'(min_q[3:0]);
    s_bin = 17'(sec_q[6:4])  * 17'd10 + 17'(sec_q[3:0]);
    sbs_d = h_bin * 17'd3600 + m_bin * 17'd60 + s_bin;
  end

  always_ff @(posedge pll_c0) begin
    if (rst) sbs_q <= '0;
    else     sbs_q <= sbs_d;
  end
`endif

  // Next-state: start wins over everything, abort next, then the symbol timer.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sym_d         = sym_q;
    sec_d         = sec_q;
    min_d         = min_q;
    hour_d        = hour_q;
    day_d         = day_q;
    frame_start_d = 1'b0;
    slip_d        = 1'b0;
    if (start) begin
      sec_d         = bus.sec_bcd;
      min_d         = bus.min_bcd;
      hour_d        = bus.hour_bcd;
      day_d         = bus.day_bcd;
      state_d       = StRun;
      cnt_d         = '0;
      sym_d         = '0;
      frame_start_d = 1'b1;
      // A PPS during the last symbol is ordinary clock drift, not a slip.
      slip_d        = (state_q == StRun) && (sym_q != 7'd99);
    end else if (abort) begin
      state_d = StIdle;
      cnt_d   = '0;
      sym_d   = '0;
    end else if (state_q == StRun) begin
      if (cnt_q == cnt_10ms_max) begin
        cnt_d = '0;
        if (sym_q == 7'd99) begin
          state_d = StWait;
          sym_d   = '0;
        end else begin
          sym_d = sym_q + 7'd1;
        end
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end
  end

  // Frame content for the symbol about to be output; fields LSB-first.
  always_comb begin
    frame_bits        = '0;
    frame_bits[4:1]   = sec_d[3:0];
    frame_bits[8:6]   = sec_d[6:4];
    frame_bits[13:10] = min_d[3:0];
    frame_bits[17:15] = min_d[6:4];
    frame_bits[23:20] = hour_d[3:0];
    frame_bits[26:25] = hour_d[5:4];
    frame_bits[33:30] = day_d[3:0];
    frame_bits[38:35] = day_d[7:4];
    frame_bits[41:40] = day_d[9:8];
`ifdef IRIG_B_SBS_EN
    frame_bits[88:80] = sbs_q[8:0];
    frame_bits[97:90] = sbs_q[16:9];
`endif
  end

  always_comb begin
    sym_p   = sym_d inside {7'd0, 7'd9, 7'd19, 7'd29, 7'd39, 7'd49,
                            7'd59, 7'd69, 7'd79, 7'd89, 7'd99};
    sym_one = frame_bits[sym_d];
    if (sym_p)        hi_limit = cnt_8ms_max;
    else if (sym_one) hi_limit = cnt_5ms_max;
    else              hi_limit = cnt_2ms_max;

    b_code_d = 1'b0;
    moni_d   = 8'h00;
    if (state_d == StRun) begin
      b_code_d = (cnt_d <= hi_limit);
      if (sym_p)        moni_d = 8'h70;
      else if (sym_one) moni_d = 8'h31;
      else              moni_d = 8'h30;
    end
  end

  always_ff @(posedge pll_c0) begin
    if (rst) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      sym_q         <= '0;
      sec_q         <= '0;
      min_q         <= '0;
      hour_q        <= '0;
      day_q         <= '0;
      b_code_q      <= 1'b0;
      moni_q        <= 8'h00;
      frame_start_q <= 1'b0;
      slip_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sym_q         <= sym_d;
      sec_q         <= sec_d;
      min_q         <= min_d;
      hour_q        <= hour_d;
      day_q         <= day_d;
      b_code_q      <= b_code_d;
      moni_q        <= moni_d;
      frame_start_q <= frame_start_d;
      slip_q        <= slip_d;
    end
  end

  assign bus.b_code_out      = b_code_q;
  assign bus.moni_b_code_out = moni_q;
  assign bus.sym_index       = sym_q;
  assign bus.frame_start     = frame_start_q;
  assign bus.slip            = slip_q;

endmodule

// File: tb/tb_irig_b_frame_sched.sv
// tb_irig_b_frame_sched
// Directed bench for irig_b_frame_sched with shortened symbol timing
// (10 clocks per symbol; P/1/0 high for 8/5/2 clocks).
module tb_irig_b_frame_sched;
  localparam logic [31:0] C10 = 32'd9;
  localparam logic [31:0] C8  = 32'd7;
  localparam logic [31:0] C5  = 32'd4;
  localparam logic [31:0] C2  = 32'd1;

  logic pll_c0 = 1'b0;
  logic rst;
  always #5 pll_c0 = ~pll_c0;

  irig_b_frame_sched_if bus ();

  irig_b_frame_sched #(
    .cnt_10ms_max(C10),
    .cnt_8ms_max (C8),
    .cnt_5ms_max (C5),
    .cnt_2ms_max (C2)
  ) dut (
    .pll_c0(pll_c0),
    .rst   (rst),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected monitor code of symbol i for the given latched time.
  function automatic logic [7:0] exp_code(input int i, input logic [6:0] s, input logic [6:0] m,
                                          input logic [5:0] h, input logic [9:0] d,
                                          input logic [16:0] sbs);
    logic b;
    b = 1'b0;
    if (i == 0 || (i % 10) == 9) return 8'h70;
    if (i >= 1 && i <= 4)   b = s[i-1];
    if (i >= 6 && i <= 8)   b = s[i-2];
    if (i >= 10 && i <= 13) b = m[i-10];
    if (i >= 15 && i <= 17) b = m[i-11];
    if (i >= 20 && i <= 23) b = h[i-20];
    if (i >= 25 && i <= 26) b = h[i-21];
    if (i >= 30 && i <= 33) b = d[i-30];
    if (i >= 35 && i <= 38) b = d[i-31];
    if (i >= 40 && i <= 41) b = d[i-32];
`ifdef IRIG_B_SBS_EN
    if (i >= 80 && i <= 88) b = sbs[i-80];
    if (i >= 90 && i <= 97) b = sbs[i-81];
`else
    b = b | (sbs[0] & 1'b0);
`endif
    return b ? 8'h31 : 8'h30;
  endfunction

  function automatic int width_of(input logic [7:0] code);
    if (code == 8'h70) return 8;
    if (code == 8'h31) return 5;
    return 2;
  endfunction

  // Caller sits at a negedge; returns at the negedge showing the response.
  task automatic pps_pulse(input logic tv);
    bus.time_valid = tv;
    bus.pps        = 1'b1;
    @(negedge pll_c0);
    bus.pps        = 1'b0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_b_code"}, 32'(bus.b_code_out), 32'd0);
    check_eq({tag, "_moni"}, 32'(bus.moni_b_code_out), 32'd0);
    check_eq({tag, "_sym"}, 32'(bus.sym_index), 32'd0);
    check_eq({tag, "_fs"}, 32'(bus.frame_start), 32'd0);
    check_eq({tag, "_slip"}, 32'(bus.slip), 32'd0);
  endtask

  // Count activity over n cycles; expects the block to stay quiet.
  task automatic check_quiet(input string tag, input int n);
    int act;
    act = 0;
    for (int k = 0; k < n; k++) begin
      @(negedge pll_c0);
      if (bus.b_code_out !== 1'b0 || bus.moni_b_code_out !== 8'h00 ||
          bus.sym_index !== 7'd0 || bus.frame_start !== 1'b0) act++;
    end
    check_eq(tag, act, 0);
  endtask

  task automatic start_checks(input string tag, input logic exp_slip);
    check_eq({tag, "_fs"}, 32'(bus.frame_start), 32'd1);
    check_eq({tag, "_b_code"}, 32'(bus.b_code_out), 32'd1);
    check_eq({tag, "_moni"}, 32'(bus.moni_b_code_out), 32'h70);
    check_eq({tag, "_sym"}, 32'(bus.sym_index), 32'd0);
    check_eq({tag, "_slip"}, 32'(bus.slip), 32'(exp_slip));
  endtask

  // Called at the frame_start negedge; ends at the negedge of the last cycle.
  task automatic scan_frame(input logic [6:0] s, input logic [6:0] m, input logic [5:0] h,
                            input logic [9:0] d, input logic [16:0] sbs);
    int hi;
    int bad;
    logic [7:0] ec;
    for (int sy = 0; sy < 100; sy++) begin
      hi = 0;
      bad = 0;
      ec = exp_code(sy, s, m, h, d, sbs);
      for (int c = 0; c < 10; c++) begin
        if (!(sy == 0 && c == 0)) @(negedge pll_c0);
        if (c == 0) begin
          check_eq($sformatf("sym_index_%0d", sy), 32'(bus.sym_index), sy);
          check_eq($sformatf("moni_%0d", sy), 32'(bus.moni_b_code_out), 32'(ec));
        end
        if (bus.moni_b_code_out !== ec || bus.sym_index !== 7'(sy)) bad++;
        if (bus.frame_start !== ((sy == 0 && c == 0) ? 1'b1 : 1'b0)) bad++;
        if (bus.slip !== 1'b0) bad++;
        if (bus.b_code_out === 1'b1) hi++;
      end
      check_eq($sformatf("high_clocks_%0d", sy), hi, width_of(ec));
      check_eq($sformatf("sym_steady_%0d", sy), bad, 0);
    end
  endtask

  initial begin
    logic [16:0] sbs_full;
    rst            = 1'b1;
    bus.pps        = 1'b0;
    bus.time_valid = 1'b0;
    bus.sec_bcd    = '0;
    bus.min_bcd    = '0;
    bus.hour_bcd   = '0;
    bus.day_bcd    = '0;
    repeat (3) @(negedge pll_c0);
    check_outputs_zero("reset");
    rst = 1'b0;
    @(negedge pll_c0);
    check_outputs_zero("idle");

    // Frame with 12:34:56 day 123; inputs scrambled after capture.
    bus.sec_bcd  = 7'h56;
    bus.min_bcd  = 7'h34;
    bus.hour_bcd = 6'h12;
    bus.day_bcd  = 10'h123;
    pps_pulse(1'b1);
    start_checks("first_start", 1'b0);
    bus.sec_bcd  = 7'h00;
    bus.min_bcd  = 7'h7f;
    bus.hour_bcd = 6'h3f;
    bus.day_bcd  = 10'h3ff;
    scan_frame(7'h56, 7'h34, 6'h12, 10'h123, 17'd45296);
    @(negedge pll_c0);
    check_outputs_zero("wait");
    check_quiet("wait_quiet", 5);

    // Early PPS at symbol 50, cnt 3.
    pps_pulse(1'b1);
    start_checks("wait_restart", 1'b0);
    repeat (503) @(negedge pll_c0);
    check_eq("pre_slip_sym", 32'(bus.sym_index), 32'd50);
    pps_pulse(1'b1);
    start_checks("slip", 1'b1);
    @(negedge pll_c0);
    check_eq("slip_one_cycle", 32'(bus.slip), 32'd0);

    // PPS on the final count of symbol 99: clean restart.
    repeat (998) @(negedge pll_c0);
    check_eq("last_sym", 32'(bus.sym_index), 32'd99);
    check_eq("last_cnt_low", 32'(bus.b_code_out), 32'd0);
    pps_pulse(1'b1);
    start_checks("clean_restart", 1'b0);

    // PPS right on frame_start restarts again.
    pps_pulse(1'b1);
    start_checks("restart_on_fs", 1'b1);

    // PPS with time_valid low aborts a running frame.
    repeat (30) @(negedge pll_c0);
    check_eq("pre_abort_sym", 32'(bus.sym_index), 32'd3);
    pps_pulse(1'b0);
    check_outputs_zero("abort");
    check_quiet("abort_quiet", 15);

    // rst at symbol 20 with a coincident PPS.
    pps_pulse(1'b1);
    repeat (200) @(negedge pll_c0);
    check_eq("pre_rst_sym", 32'(bus.sym_index), 32'd20);
    rst     = 1'b1;
    bus.pps = 1'b1;
    @(negedge pll_c0);
    rst     = 1'b0;
    bus.pps = 1'b0;
    check_outputs_zero("mid_rst");
    check_quiet("rst_quiet", 20);

    // PPS without valid time from IDLE.
    pps_pulse(1'b0);
    check_outputs_zero("invalid_pps");
    check_quiet("invalid_quiet", 15);

    // 23:59:59 day 001: SBS region.
    bus.sec_bcd  = 7'h59;
    bus.min_bcd  = 7'h59;
    bus.hour_bcd = 6'h23;
    bus.day_bcd  = 10'h001;
    sbs_full     = 17'h1517F;
    pps_pulse(1'b1);
    start_checks("sbs_start", 1'b0);
    repeat (800) @(negedge pll_c0);
    for (int sy = 80; sy < 99; sy++) begin
      check_eq($sformatf("sbs_moni_%0d", sy), 32'(bus.moni_b_code_out),
               32'(exp_code(sy, 7'h59, 7'h59, 6'h23, 10'h001, sbs_full)));
      repeat (10) @(negedge pll_c0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
